// File: rtl/branch_checkpoint_ctrl_if.sv
// Rename/execute-facing bus of the branch checkpoint controller.
interface branch_checkpoint_ctrl_if #(
    parameter int unsigned BRANCH_NUM = 4,
    parameter int unsigned AL_SIZE    = 64
);
    localparam int unsigned AL_IDX = $clog2(AL_SIZE);
    localparam int unsigned B_IDX  = $clog2(BRANCH_NUM);

    // Allocation from rename
    logic              alloc_req;
    logic [AL_IDX-1:0] alloc_id;
    logic              alloc_color;
    logic              alloc_ds;
    logic              alloc_gnt;
    logic [B_IDX-1:0]  alloc_slot;
    logic              full;

    // Resolution from execute
    logic              resolve_valid;
    logic [AL_IDX-1:0] resolve_id;
    logic              resolve_color;
    logic              resolve_miss;

    // Recovery command and status
    logic              recover_valid;
    logic [B_IDX-1:0]  recover_slot;
    logic [AL_IDX-1:0] recover_id_ds;
    logic              recover_color_ds;
    logic              busy;
    logic [BRANCH_NUM-1:0] slot_valid;
    logic [B_IDX:0]    free_count;

    modport master (
        output alloc_req, alloc_id, alloc_color, alloc_ds,
        output resolve_valid, resolve_id, resolve_color, resolve_miss,
        input  alloc_gnt, alloc_slot, full,
        input  recover_valid, recover_slot, recover_id_ds, recover_color_ds,
        input  busy, slot_valid, free_count
    );

    modport slave (
        input  alloc_req, alloc_id, alloc_color, alloc_ds,
        input  resolve_valid, resolve_id, resolve_color, resolve_miss,
        output alloc_gnt, alloc_slot, full,
        output recover_valid, recover_slot, recover_id_ds, recover_color_ds,
        output busy, slot_valid, free_count
    );
endinterface

// File: rtl/branch_checkpoint_ctrl.sv
// Branch checkpoint slot allocator with misprediction squash and timed flush.
module branch_checkpoint_ctrl #(
    parameter int unsigned BRANCH_NUM     = 4,
    parameter int unsigned AL_SIZE        = 64,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    branch_checkpoint_ctrl_if.slave bus
);
    localparam int unsigned AL_IDX = $clog2(AL_SIZE);
    localparam int unsigned B_IDX  = $clog2(BRANCH_NUM);
    localparam int unsigned FC_W   = B_IDX + 1;
    localparam int unsigned CNT_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [BRANCH_NUM-1:0] valid_q, valid_d;
    logic [AL_IDX-1:0]     id_q [BRANCH_NUM];
    logic [BRANCH_NUM-1:0] color_q;
    logic [BRANCH_NUM-1:0] ds_q;
    logic [B_IDX-1:0]      wp_q, wp_d;

    logic                  rec_valid_q, rec_valid_d;
    logic [B_IDX-1:0]      rec_slot_q, rec_slot_d;
    logic [AL_IDX-1:0]     rec_id_q, rec_id_d;
    logic                  rec_color_q, rec_color_d;

    logic [BRANCH_NUM-1:0] hit;
    logic [BRANCH_NUM-1:0] younger;
    logic                  hit_any;
    logic [B_IDX-1:0]      hit_slot;
    logic                  miss_hit;
    logic                  ok_hit;
    logic                  full;
    logic                  alloc_gnt;
    logic [AL_IDX-1:0]     rid_inc;
    logic                  rid_wrap;
    logic [FC_W-1:0]       free_cnt;

    // Match the resolving branch against live slots and classify younger slots
    always_comb begin
        hit     = '0;
        younger = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            hit[i] = valid_q[i] && (id_q[i] == bus.resolve_id)
                     && (color_q[i] == bus.resolve_color);
            if (color_q[i] == bus.resolve_color) begin
                younger[i] = id_q[i] > bus.resolve_id;
            end else begin
                younger[i] = id_q[i] < bus.resolve_id;
            end
        end
    end

    // Encode the (at most one) matching slot
    always_comb begin
        hit_slot = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            if (hit[i]) begin
                hit_slot = B_IDX'(i);
            end
        end
    end

    assign hit_any   = |hit;
    assign miss_hit  = bus.resolve_valid && hit_any && bus.resolve_miss;
    assign ok_hit    = bus.resolve_valid && hit_any && !bus.resolve_miss;
    assign full      = valid_q[wp_q];
    assign alloc_gnt = bus.alloc_req && (state_q == IDLE) && !full && !miss_hit;
    assign rid_inc   = bus.resolve_id + AL_IDX'(1);
    assign rid_wrap  = (rid_inc == '0);

    // Count free slots from registered valid bits
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            free_cnt = free_cnt + FC_W'(!valid_q[i]);
        end
    end

    // Next-state: squash on miss, otherwise retire/allocate and run flush timer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        wp_d        = wp_q;
        rec_valid_d = 1'b0;
        rec_slot_d  = rec_slot_q;
        rec_id_d    = rec_id_q;
        rec_color_d = rec_color_q;

        if (miss_hit) begin
            valid_d    = valid_q & ~(younger | hit);
            wp_d       = hit_slot + B_IDX'(1);
            rec_valid_d = 1'b1;
            rec_slot_d = hit_slot;
            if (ds_q[hit_slot]) begin
                rec_id_d    = rid_inc;
                rec_color_d = rid_wrap ? !bus.resolve_color : bus.resolve_color;
            end else begin
                rec_id_d    = bus.resolve_id;
                rec_color_d = bus.resolve_color;
            end
            state_d = FLUSH;
            cnt_d   = CNT_RELOAD;
        end else begin
            if (ok_hit) begin
                valid_d = valid_d & ~hit;
            end
            if (alloc_gnt) begin
                valid_d[wp_q] = 1'b1;
                wp_d          = wp_q + B_IDX'(1);
            end
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, slot and recovery registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            color_q     <= '0;
            ds_q        <= '0;
            wp_q        <= '0;
            rec_valid_q <= 1'b0;
            rec_slot_q  <= '0;
            rec_id_q    <= '0;
            rec_color_q <= 1'b0;
            for (int i = 0; i < BRANCH_NUM; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            wp_q        <= wp_d;
            rec_valid_q <= rec_valid_d;
            rec_slot_q  <= rec_slot_d;
            rec_id_q    <= rec_id_d;
            rec_color_q <= rec_color_d;
            if (alloc_gnt) begin
                id_q[wp_q]    <= bus.alloc_id;
                color_q[wp_q] <= bus.alloc_color;
                ds_q[wp_q]    <= bus.alloc_ds;
            end
        end
    end

    assign bus.alloc_gnt        = alloc_gnt;
    assign bus.alloc_slot       = wp_q;
    assign bus.full             = full;
    assign bus.recover_valid    = rec_valid_q;
    assign bus.recover_slot     = rec_slot_q;
    assign bus.recover_id_ds    = rec_id_q;
    assign bus.recover_color_ds = rec_color_q;
    assign bus.busy             = (state_q == FLUSH);
    assign bus.slot_valid       = valid_q;
    assign bus.free_count       = free_cnt;
endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Scoreboard bench for branch_checkpoint_ctrl: directed plan cases then random traffic.
module tb_branch_checkpoint_ctrl;
    localparam int N  = 4;
    localparam int AL = 64;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_checkpoint_ctrl_if #(.BRANCH_NUM(N), .AL_SIZE(AL)) bus ();

    branch_checkpoint_ctrl #(.BRANCH_NUM(N), .AL_SIZE(AL), .RECOVER_CYCLES(RC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Program-order sequence number = {color, id}; 7 bits
    typedef struct {
        int cyc;
        int slot;
        int id;
        int color;
    } rec_t;
    rec_t exp_q[$];

    bit m_valid[N];
    int m_seq[N];
    bit m_ds[N];
    int m_wp;
    int m_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit younger(input int si, input int sr);
        int d;
        d = (si - sr) & 127;
        return (d > 0) && (d < AL);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_seq[i]   = 0;
            m_ds[i]    = 1'b0;
        end
        m_wp   = 0;
        m_busy = 0;
    endtask

    // One clock: drive, compare combinational/registered status, advance model
    task automatic step(input bit r, input bit req, input int aseq, input bit ads,
                        input bit rv, input int rseq, input bit rmiss,
                        output bit gnt_o, output bit miss_o);
        int h;
        bit hit;
        bit miss;
        bit gnt;
        logic [N-1:0] sv;
        int fc;
        int rs;
        @(negedge clk);
        rst               = r;
        bus.alloc_req     = req;
        bus.alloc_id      = 6'(aseq & 63);
        bus.alloc_color   = 1'((aseq >> 6) & 1);
        bus.alloc_ds      = ads;
        bus.resolve_valid = rv;
        bus.resolve_id    = 6'(rseq & 63);
        bus.resolve_color = 1'((rseq >> 6) & 1);
        bus.resolve_miss  = rmiss;
        #2;
        h = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_seq[i] == (rseq & 127)) h = i;
        end
        hit  = rv && (h >= 0);
        miss = hit && rmiss;
        gnt  = req && (m_busy == 0) && !m_valid[m_wp] && !miss;
        sv = '0;
        fc = 0;
        for (int i = 0; i < N; i++) begin
            sv[i] = m_valid[i];
            if (!m_valid[i]) fc++;
        end
        check("alloc_gnt",  32'(bus.alloc_gnt),  32'(gnt));
        check("alloc_slot", 32'(bus.alloc_slot), 32'(m_wp));
        check("full",       32'(bus.full),       32'(m_valid[m_wp]));
        check("busy",       32'(bus.busy),       32'(m_busy > 0));
        check("slot_valid", 32'(bus.slot_valid), 32'(sv));
        check("free_count", 32'(bus.free_count), 32'(fc));
        gnt_o  = gnt && !r;
        miss_o = miss && !r;
        if (r) begin
            model_clear();
        end else if (miss) begin
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && (i == h || younger(m_seq[i], rseq & 127))) m_valid[i] = 1'b0;
            end
            m_wp = (h + 1) % N;
            rs = ((rseq & 127) + (m_ds[h] ? 1 : 0)) & 127;
            exp_q.push_back('{cyc + 1, h, rs & 63, rs >> 6});
            m_busy = RC;
        end else begin
            if (hit) m_valid[h] = 1'b0;
            if (gnt) begin
                m_valid[m_wp] = 1'b1;
                m_seq[m_wp]   = aseq & 127;
                m_ds[m_wp]    = ads;
                m_wp          = (m_wp + 1) % N;
            end
            if (m_busy > 0) m_busy--;
        end
    endtask

    // Look at registered outputs just after the edge that follows a step
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // Recovery monitor: pops the scoreboard whenever a recovery pulse appears
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            #3;
            if (bus.recover_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("recover_valid_unexpected", 32'(bus.recover_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("recover_cycle", 32'(cyc), 32'(e.cyc));
                    check("recover_slot", 32'(bus.recover_slot), 32'(e.slot));
                    check("recover_id_ds", 32'(bus.recover_id_ds), 32'(e.id));
                    check("recover_color_ds", 32'(bus.recover_color_ds), 32'(e.color));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("recover_valid_missing", 32'(bus.recover_valid), 32'd1);
            end
        end
    end

    initial begin
        bit g, m;
        int s;
        int rseq;
        int live[$];
        bit r, req, ads, rv, rmiss;

        rst = 1'b1;
        bus.alloc_req = 1'b0; bus.alloc_id = '0; bus.alloc_color = 1'b0; bus.alloc_ds = 1'b0;
        bus.resolve_valid = 1'b0; bus.resolve_id = '0; bus.resolve_color = 1'b0; bus.resolve_miss = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        check("rst_recover_valid", 32'(bus.recover_valid), 32'd0);
        check("rst_recover_slot", 32'(bus.recover_slot), 32'd0);
        check("rst_recover_id", 32'(bus.recover_id_ds), 32'd0);
        check("rst_recover_color", 32'(bus.recover_color_ds), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_free_count", 32'(bus.free_count), 32'd4);
        check("rst_alloc_gnt", 32'(bus.alloc_gnt), 32'd0);
        check("rst_slot_valid", 32'(bus.slot_valid), 32'd0);
        check("rst_alloc_slot", 32'(bus.alloc_slot), 32'd0);

        // Fill four slots, then a fifth request is refused
        step(0, 1, 3, 0, 0, 0, 0, g, m);
        step(0, 1, 7, 1, 0, 0, 0, g, m);
        step(0, 1, 9, 0, 0, 0, 0, g, m);
        step(0, 1, 12, 0, 0, 0, 0, g, m);
        peek();
        check("tp_full", 32'(bus.full), 32'd1);
        check("tp_free_zero", 32'(bus.free_count), 32'd0);
        step(0, 1, 20, 0, 0, 0, 0, g, m);
        // Miss on id 7 with delay slot
        step(0, 0, 0, 0, 1, 7, 1, g, m);
        peek();
        check("tp_miss_recover_slot", 32'(bus.recover_slot), 32'd1);
        check("tp_miss_recover_id", 32'(bus.recover_id_ds), 32'd8);
        check("tp_miss_slot_valid", 32'(bus.slot_valid), 32'b0001);
        check("tp_miss_wp", 32'(bus.alloc_slot), 32'd2);
        repeat (3) step(0, 1, 20, 0, 0, 0, 0, g, m);

        // Color wrap on recovery id
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        step(0, 1, 62, 1, 0, 0, 0, g, m);
        step(0, 1, 65, 0, 0, 0, 0, g, m);
        step(0, 0, 0, 0, 1, 62, 1, g, m);
        peek();
        check("tp_wrap1_id", 32'(bus.recover_id_ds), 32'd63);
        check("tp_wrap1_color", 32'(bus.recover_color_ds), 32'd0);
        check("tp_wrap1_valid", 32'(bus.slot_valid), 32'd0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, g, m);
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        step(0, 1, 63, 1, 0, 0, 0, g, m);
        step(0, 1, 65, 0, 0, 0, 0, g, m);
        step(0, 0, 0, 0, 1, 63, 1, g, m);
        peek();
        check("tp_wrap2_id", 32'(bus.recover_id_ds), 32'd0);
        check("tp_wrap2_color", 32'(bus.recover_color_ds), 32'd1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, g, m);

        // Correct resolve of slot 0 while full, with alloc in same and next cycle
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        step(0, 1, 3, 0, 0, 0, 0, g, m);
        step(0, 1, 7, 0, 0, 0, 0, g, m);
        step(0, 1, 9, 0, 0, 0, 0, g, m);
        step(0, 1, 12, 0, 0, 0, 0, g, m);
        step(0, 1, 20, 0, 1, 3, 0, g, m);
        peek();
        check("tp_same_slot_valid", 32'(bus.slot_valid), 32'b1110);
        check("tp_same_wp", 32'(bus.alloc_slot), 32'd0);
        step(0, 1, 20, 0, 0, 0, 0, g, m);
        peek();
        check("tp_same_alloc", 32'(bus.slot_valid), 32'b1111);

        // Nested miss during flush on an older slot
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        step(0, 1, 3, 0, 0, 0, 0, g, m);
        step(0, 1, 7, 0, 0, 0, 0, g, m);
        step(0, 1, 9, 0, 0, 0, 0, g, m);
        step(0, 0, 0, 0, 1, 7, 1, g, m);
        step(0, 0, 0, 0, 1, 3, 1, g, m);
        peek();
        check("tp_nest_slot", 32'(bus.recover_slot), 32'd0);
        check("tp_nest_busy", 32'(bus.busy), 32'd1);
        check("tp_nest_wp", 32'(bus.alloc_slot), 32'd1);
        repeat (4) step(0, 1, 30, 0, 0, 0, 0, g, m);

        // Unmatched resolve, then reset in the middle of a flush
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        step(0, 1, 3, 0, 0, 0, 0, g, m);
        step(0, 1, 7, 0, 0, 0, 0, g, m);
        step(0, 0, 0, 0, 1, 40, 1, g, m);
        peek();
        check("tp_unmatched_valid", 32'(bus.slot_valid), 32'b0011);
        check("tp_unmatched_busy", 32'(bus.busy), 32'd0);
        step(0, 0, 0, 0, 1, 3, 1, g, m);
        step(1, 0, 0, 0, 0, 0, 0, g, m);
        peek();
        check("tp_rst_busy", 32'(bus.busy), 32'd0);
        check("tp_rst_valid", 32'(bus.slot_valid), 32'd0);
        check("tp_rst_wp", 32'(bus.alloc_slot), 32'd0);

        // Random traffic in program order
        s = $urandom_range(0, 127);
        for (int k = 0; k < 2000; k++) begin
            r     = ($urandom_range(0, 99) == 0);
            req   = !r && ($urandom_range(0, 99) < 60);
            ads   = 1'($urandom_range(0, 1));
            rv    = ($urandom_range(0, 99) < 40);
            rmiss = ($urandom_range(0, 99) < 25);
            live.delete();
            for (int i = 0; i < N; i++) if (m_valid[i]) live.push_back(m_seq[i]);
            if (live.size() > 0 && $urandom_range(0, 99) < 80)
                rseq = live[$urandom_range(0, live.size() - 1)];
            else
                rseq = $urandom_range(0, 127);
            step(r, req, s, ads, rv, rseq, rmiss, g, m);
            if (r) s = $urandom_range(0, 127);
            else if (m) s = (rseq + 2) & 127;
            else if (g) s = (s + $urandom_range(1, 3)) & 127;
        end

        repeat (4) step(0, 0, 0, 0, 0, 0, 0, g, m);
        check("pending_recover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_checkpoint_ctrl.md
# branch_checkpoint_ctrl

Allocates, frees and squashes branch checkpoint slots for out-of-order rename and recovery. Rename requests a slot per branch and uses `alloc_slot` as the write index into the checkpoint snapshot arrays (free-list head, rename map, GHR, TAGE CSRs). Execute reports branch resolution. On a misprediction the block picks the matching slot, squashes every younger slot, and emits one registered recovery command (slot index plus delay-slot-adjusted active-list id and color). It then holds the front end in a timed FLUSH state.

## Interface
- `BRANCH_NUM`, default 4: number of checkpoint slots (power of 2).
- `AL_SIZE`, default 64: active-list entries (power of 2); `AL_IDX` = log2(`AL_SIZE`), `B_IDX` = log2(`BRANCH_NUM`).
- `RECOVER_CYCLES`, default 2: cycles `busy` stays high per accepted miss (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `alloc_req` in 1: rename has a branch needing a checkpoint.
- `alloc_id` in `AL_IDX`: active-list id of the branch.
- `alloc_color` in 1: color bit of the branch.
- `alloc_ds` in 1: the branch has a delay slot.
- `alloc_gnt` out 1: allocation accepted this cycle (combinational).
- `alloc_slot` out `B_IDX`: slot index to snapshot into; equals the write pointer.
- `full` out 1: `slot_valid[wp]`; rename must stall.
- `resolve_valid` in 1: a branch resolved this cycle.
- `resolve_id` in `AL_IDX`, `resolve_color` in 1, `resolve_miss` in 1: identity and outcome of the resolved branch.
- `recover_valid` out 1: one-cycle recovery pulse (registered).
- `recover_slot` out `B_IDX`: checkpoint to restore.
- `recover_id_ds` out `AL_IDX`, `recover_color_ds` out 1: last surviving active-list id and its color.
- `busy` out 1: recovery in progress; front end and rename must stall.
- `slot_valid` out `BRANCH_NUM`: live slots.
- `free_count` out `B_IDX`+1: number of clear `slot_valid` bits.

## Operation
- Per-slot registers: valid, id, color, ds.
- Write pointer `wp` is circular, `B_IDX` bits, and wraps modulo `BRANCH_NUM`.
- Allocation:
  - `alloc_gnt` = `alloc_req` & state==IDLE & !`full` & !miss_hit.
  - On grant: slot[wp] <= {1, alloc_id, alloc_color, alloc_ds}; wp <= wp+1.
- Hit detection: hit[i] = valid[i] & id[i]==`resolve_id` & color[i]==`resolve_color`. At most one hit. A `resolve_valid` with no hit is ignored.
- Correct resolve (hit, !`resolve_miss`): clear valid[hit]. Allowed in any state.
- Miss (hit & `resolve_miss`), accepted in IDLE or FLUSH:
  - Younger(i): (color[i]==c & id[i]>r) | (color[i]!=c & id[i]<r), with r=`resolve_id`, c=`resolve_color`.
  - Clear valid for every younger slot. The missing slot's own valid is also cleared.
  - wp <= hit_slot+1.
  - Latch recover_slot = hit_slot.
  - If ds[hit]: recover_id_ds = r+1 mod `AL_SIZE`, and recover_color_ds = !c when r+1 wraps to 0, else c. Otherwise recover_id_ds = r and recover_color_ds = c.
  - recover_valid <= 1; state <= FLUSH; cnt <= `RECOVER_CYCLES`-1.
- FSM:
  - IDLE → FLUSH on an accepted miss.
  - In FLUSH, cnt decrements each cycle. FLUSH → IDLE when cnt==0 and there is no new miss.
  - A miss in FLUSH restarts the flush: the slot is necessarily older because younger slots are already squashed. The block reissues recover_valid and reloads cnt.
- `busy` = state==FLUSH.
- `free_count` = popcount(!slot_valid), computed from registered state.

## Timing
- Reset values: slot_valid=0, wp=0, state=IDLE, cnt=0, recover_valid=0, recover_slot=0, recover_id_ds=0, recover_color_ds=0, busy=0, full=0, free_count=`BRANCH_NUM`, alloc_gnt=0.
- A grant at edge T makes the slot valid at T+1.
- A miss accepted in cycle T:
  - recover_valid is high in T+1 only.
  - busy is high for cycles T+1..T+`RECOVER_CYCLES`.
  - Allocation is possible again at T+`RECOVER_CYCLES`+1.
- `full` and `alloc_gnt` use registered slot_valid. A slot freed in cycle T is allocatable in T+1, never in T.
- Miss and alloc_req in the same cycle: the miss wins, alloc_gnt=0, and no slot is written.
- Correct resolve and alloc in the same cycle on different slots: both take effect.
- Wrap: wp=`BRANCH_NUM`-1 with a grant gives wp=0.
- A miss on slot `BRANCH_NUM`-1 sets wp=0.
- Reset mid-FLUSH returns all registers to reset values in the next cycle.

## Test plan
- Fill: 4 grants with ids 3, 7, 9, 12 (color 0) → alloc_slot 0, 1, 2, 3; full=1 after the 4th; a 5th alloc_req gets gnt=0; free_count=0.
- Miss with ds: slots as above, miss id 7 color 0, ds=1 → next cycle recover_valid=1, recover_slot=1, recover_id_ds=8, slot_valid=0001, wp=2; busy high exactly 2 cycles.
- Color wrap: slots {id 62 c0, id 1 c1}, miss id 62 c0 with ds=1 → recover_id_ds=63, color 0, slot for id 1 squashed. A second run with miss id 63 c0, ds=1 → recover_id_ds=0, color 1.
- Same-cycle events: correct resolve of slot 0 together with an alloc_req while full=1 → gnt=0 that cycle and gnt=1 with alloc_slot=0 the next cycle (after wp wrap).
- Nested miss: during FLUSH, a miss on older slot 0 → second recover_valid pulse with recover_slot=0, busy extended `RECOVER_CYCLES` from the restart.
- Unmatched resolve (id 40) → no state change; reset asserted mid-FLUSH → busy=0, slot_valid=0, wp=0 the next cycle.
